game_engine: RTL

// Ball-and-paddle game state machine; sits directly upstream of video_encoder and

---
 rtl/game_engine.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/game_engine.sv
// -----------------------------------------------------------------------------
// game_engine
//   Ball-and-paddle game controller feeding the video encoder. Physics advance
//   once per video frame (frame_tick). Paddle moves on button levels, the ball
//   bounces off the side/top walls and the paddle, paddle hits score a point,
//   and a ball reaching the bottom edge costs a life. Every output is a flop
//   and changes one clk after the frame_tick cycle that caused it.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous reset, active-low
//   frame_tick : one-cycle pulse per frame; the only cycle in which state moves
//   start      : level, starts/restarts a game from IDLE or OVER
//   btn_left   : level, move paddle left
//   btn_right  : level, move paddle right
//   game_over  : high while state is OVER
//   state      : 00 IDLE, 01 SERVE, 10 PLAY, 11 OVER
//   score      : paddle hits this game, saturating at 63
//   lives      : lives remaining
//   ball_x/y   : ball top-left corner
//   paddle_x   : paddle left column
//   paddle_y   : paddle top row (constant)
// -----------------------------------------------------------------------------
module game_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 64,
  parameter int PADDLE_Y     = 440,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        game_over,
  output logic [1:0]  state,
  output logic [5:0]  score,
  output logic [5:0]  lives,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] paddle_x,
  output logic [10:0] paddle_y
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [10:0] BALL_CX    = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0] BALL_CY    = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] PAD_INIT   = 11'((H_RES - PADDLE_W) / 2);
  localparam logic [10:0] PAD_MAX    = 11'(H_RES - PADDLE_W);
  localparam logic [10:0] PAD_STEP   = 11'(PADDLE_SPEED);
  localparam logic [10:0] HIT_Y      = 11'(PADDLE_Y - BALL_SIZE);
  localparam logic [5:0]  LIVES_INIT = 6'(LIVES);
  localparam logic [5:0]  SCORE_MAX  = 6'd63;

  // Ball arithmetic is done 12-bit signed so a step past column/row 0 shows
  // up as a negative value instead of wrapping to a large positive one.
  localparam logic signed [11:0] X_MAX  = 12'(H_RES - BALL_SIZE);
  localparam logic signed [11:0] S_BSZ  = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_STEP = 12'(BALL_SPEED);
  localparam logic signed [11:0] S_PTOP = 12'(PADDLE_Y);
  localparam logic signed [11:0] S_PW   = 12'(PADDLE_W);
  localparam logic signed [11:0] S_VRES = 12'(V_RES);

  localparam int               CNT_W    = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_t            state_q, state_d;
  logic [5:0]        score_q, score_d;
  logic [5:0]        lives_q, lives_d;
  logic [10:0]       ball_x_q, ball_x_d;
  logic [10:0]       ball_y_q, ball_y_d;
  logic [10:0]       paddle_x_q, paddle_x_d;
  logic              dx_q, dx_d;             // 1 = moving right
  logic              dy_q, dy_d;             // 1 = moving down
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              game_over_q;

  logic [10:0]        pad_next;
  logic signed [11:0] bx_s, by_s, px_s, nx, ny;
  logic               hit, miss;

  // Paddle position after this frame's button input; used both as the
  // registered update and as the paddle the ball is tested against.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    pad_next = paddle_x_q;
    if (btn_left && !btn_right) begin
      pad_next = (paddle_x_q < PAD_STEP) ? '0 : paddle_x_q - PAD_STEP;
    end else if (btn_right && !btn_left) begin
      pad_next = (paddle_x_q > PAD_MAX - PAD_STEP) ? PAD_MAX : paddle_x_q + PAD_STEP;
    end
  end

  assign bx_s = signed'({1'b0, ball_x_q});
  assign by_s = signed'({1'b0, ball_y_q});
  assign px_s = signed'({1'b0, pad_next});
  assign nx   = dx_q ? (bx_s + S_STEP) : (bx_s - S_STEP);
  assign ny   = dy_q ? (by_s + S_STEP) : (by_s - S_STEP);

  // Paddle hit: falling ball whose bottom edge crosses the paddle top this
  // frame while horizontally overlapping the already-moved paddle.
  assign hit  = dy_q
             && (by_s + S_BSZ <= S_PTOP)
             && (ny + S_BSZ > S_PTOP)
             && (bx_s + S_BSZ > px_s)
             && (bx_s < px_s + S_PW);
  assign miss = !hit && (ny + S_BSZ >= S_VRES);

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    paddle_x_d = paddle_x_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    cnt_d      = cnt_q;

    if (frame_tick) begin
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            state_d  = SERVE;
            score_d  = '0;
            lives_d  = LIVES_INIT;
            ball_x_d = BALL_CX;
            ball_y_d = BALL_CY;
            cnt_d    = '0;
          end
        end

        SERVE: begin
          paddle_x_d = pad_next;
          ball_x_d   = BALL_CX;
          ball_y_d   = BALL_CY;
          if (cnt_q == CNT_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
            dx_d    = 1'b1;
            dy_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        PLAY: begin
          paddle_x_d = pad_next;

          if (nx <= 12'sd0) begin
            ball_x_d = '0;
            dx_d     = 1'b1;
          end else if (nx >= X_MAX) begin
            ball_x_d = X_MAX[10:0];
            dx_d     = 1'b0;
          end else begin
            ball_x_d = nx[10:0];
          end

          if (hit) begin
            ball_y_d = HIT_Y;
            dy_d     = 1'b0;
            if (score_q != SCORE_MAX) score_d = score_q + 6'd1;
          end else if (ny <= 12'sd0) begin
            ball_y_d = '0;
            dy_d     = 1'b1;
          end else begin
            ball_y_d = ny[10:0];
          end

          // A miss overrides the motion above: the ball either freezes where
          // it was (last life) or goes back to the centre for a new serve.
          if (miss) begin
            ball_x_d = ball_x_q;
            ball_y_d = ball_y_q;
            dx_d     = dx_q;
            dy_d     = dy_q;
            if (lives_q != '0) lives_d = lives_q - 6'd1;
            if (lives_q <= 6'd1) begin
              state_d = OVER;
            end else begin
              state_d  = SERVE;
              ball_x_d = BALL_CX;
              ball_y_d = BALL_CY;
              cnt_d    = '0;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: all state flops use non-blocking '<=' and reset asynchronously on
  // rst low; release is seen on the next clk edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      ball_x_q    <= BALL_CX;
      ball_y_q    <= BALL_CY;
      paddle_x_q  <= PAD_INIT;
      dx_q        <= 1'b1;
      dy_q        <= 1'b0;
      cnt_q       <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      paddle_x_q  <= paddle_x_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cnt_q       <= cnt_d;
      game_over_q <= (state_d == OVER);
    end
  end

  assign game_over = game_over_q;
  assign state     = state_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign paddle_x  = paddle_x_q;
  assign paddle_y  = 11'(PADDLE_Y);

endmodule
